inst_fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the decoder. It buffers fetched instruction/PC pairs in a small circular FIFO and presents them to decode through a valid/ready handshake, so a decode stall does not lose fetched words. On any control-flow redirect it is emptied in one cycle. When empty it drives a NOP so decode never sees stale data.

---
 rtl/inst_fetch_queue_pkg.sv | 27 ++
 rtl/inst_fetch_queue_storage.sv | 35 +++
 rtl/inst_fetch_queue.sv | 98 +++++++++
 tb/tb_inst_fetch_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// Module      : inst_fetch_queue_pkg
// Description : Shared widths and constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

    localparam int          IFQ_ISA_WIDTH = 32;
    localparam int          IFQ_DEPTH     = 4;
    localparam int          DROP_W        = 8;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    // Saturating accumulate for the flush-drop statistic.
    function automatic logic [DROP_W-1:0] sat_add_drops(
        input logic [DROP_W-1:0] acc,
        input logic [31:0]       inc
    );
        logic [32:0] sum;
        sum = {{(33-DROP_W){1'b0}}, acc} + {1'b0, inc};
        return (sum > 33'((1 << DROP_W) - 1)) ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_storage.sv
// ============================================================================
// Module      : ifq_storage
// Description : DEPTH x WIDTH register array, one write port, async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 2 * IFQ_ISA_WIDTH,
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    // Contents survive reset and flush; only the pointers define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Circular fetch-to-decode FIFO with one-cycle flush and NOP
//               output when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int ISA_WIDTH = IFQ_ISA_WIDTH,
    parameter int DEPTH     = IFQ_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ISA_WIDTH-1:0]       in_instr,
    input  logic [ISA_WIDTH-1:0]       in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ISA_WIDTH-1:0]       out_instr,
    output logic [ISA_WIDTH-1:0]       out_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_W-1:0]          flush_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DROP_W-1:0]      drops_q, drops_d;
    logic                   push, pop;
    logic [2*ISA_WIDTH-1:0] rd_data;

    // in_ready depends on occupancy only, so a full queue never accepts
    // a word even when decode pops in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drops_d  = drops_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drops_d  = sat_add_drops(drops_q, 32'(count_q - CNT_W'(pop)));
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drops_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drops_q  <= drops_d;
        end
    end

    ifq_storage #(
        .WIDTH (2 * ISA_WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clock   (clock),
        .wr_en   (push && !flush),
        .wr_addr (wr_ptr_q),
        .wr_data ({in_instr, in_pc}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign out_instr   = out_valid ? rd_data[2*ISA_WIDTH-1:ISA_WIDTH] : ISA_WIDTH'(NOP_INSTR);
    assign out_pc      = out_valid ? rd_data[ISA_WIDTH-1:0] : '0;
    assign count       = count_q;
    assign flush_drops = drops_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Bench for inst_fetch_queue against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_instr = '0;
    logic [W-1:0]  in_pc = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_instr;
    logic [W-1:0]  out_pc;
    logic [2:0]    count;
    logic [7:0]    flush_drops;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] mq[$];
    int          mdrops = 0;

    always #5 clock = ~clock;

    inst_fetch_queue #(.ISA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count),
        .flush_drops (flush_drops)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the queue contents are the words accepted and not yet consumed.
    task automatic model_edge();
        int sz;
        bit mpush, mpop;
        sz    = mq.size();
        mpush = in_valid && (sz != DEPTH);
        mpop  = out_ready && (sz != 0);
        if (flush) begin
            mdrops = mdrops + sz - int'(mpop);
            if (mdrops > 255) mdrops = 255;
            mq.delete();
        end else begin
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back({in_instr, in_pc});
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        chk("in_ready",    64'(in_ready),    64'(sz != DEPTH));
        chk("out_valid",   64'(out_valid),   64'(sz != 0));
        chk("out_instr",   64'(out_instr),   (sz != 0) ? 64'(mq[0][63:32]) : 64'd0);
        chk("out_pc",      64'(out_pc),      (sz != 0) ? 64'(mq[0][31:0])  : 64'd0);
        chk("count",       64'(count),       64'(sz));
        chk("flush_drops", 64'(flush_drops), 64'(mdrops));
    endtask

    // Called at a falling edge: drive, clock, update model, check.
    task automatic step(input logic iv, input logic [W-1:0] ins, input logic [W-1:0] pc,
                        input logic fl, input logic ordy);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        compare_all();
        reset = 1'b1;
        @(negedge clock);
        compare_all();
        chk("reset_count",   64'(count),     64'd0);
        chk("reset_ready",   64'(in_ready),  64'd1);
        chk("reset_valid",   64'(out_valid), 64'd0);
        chk("reset_instr",   64'(out_instr), 64'd0);

        // Fill to full, reject a fifth word, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h2008_0001 + W'(i), W'(4 * i), 1'b0, 1'b0);
        chk("full_count", 64'(count),    64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0, 1'b0);
        chk("fifth_rejected", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    64'(out_pc),    64'(4 * i));
            chk("drain_instr", 64'(out_instr), 64'(32'h2008_0001 + i));
            step(1'b0, '0, '0, 1'b0, 1'b1);
        end
        chk("drained_count", 64'(count), 64'd0);

        // Streaming: one in, one out per cycle; pointers wrap twice.
        step(1'b1, 32'h1000_0000, 32'h400, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 32'h1000_0000 + W'(i), W'(32'h400 + 4 * i), 1'b0, 1'b1);
            chk("stream_count", 64'(count),  64'd1);
            chk("stream_pc",    64'(out_pc), 64'(32'h400 + 4 * i));
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush with three entries and a concurrent push and pop.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3000_0000 + W'(i), W'(32'h800 + 4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h3000_00FF, 32'h900, 1'b1, 1'b1);
        chk("flush_count", 64'(count),       64'd0);
        chk("flush_valid", 64'(out_valid),   64'd0);
        chk("flush_drops", 64'(flush_drops), 64'd2);

        // Full with simultaneous pop request and push attempt.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h4000_0000 + W'(i), W'(32'hA00 + 4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h4000_00FF, 32'hB00, 1'b0, 1'b1);
        chk("fullpop_count", 64'(count),    64'd3);
        chk("fullpop_ready", 64'(in_ready), 64'd1);
        chk("fullpop_head",  64'(out_pc),   64'h0A04);

        // Asynchronous reset between edges with two entries.
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("pre_reset_count", 64'(count), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 64'(count),       64'd0);
        chk("async_valid", 64'(out_valid),   64'd0);
        chk("async_drops", 64'(flush_drops), 64'd0);
        mq.delete();
        mdrops = 0;
        #1 reset = 1'b1;
        @(negedge clock);
        compare_all();

        // Random traffic: balanced, then stall-heavy with frequent flushes.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, W'($urandom), W'($urandom), ($urandom % 16) == 0, ($urandom % 2) == 0);
        for (int i = 0; i < 1500; i++)
            step(($urandom % 8) != 0, W'($urandom), W'($urandom), ($urandom % 8) == 0, ($urandom % 5) == 0);
        chk("drops_saturated", 64'(flush_drops), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
